// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, code width helper
// and the idle levels of the active-low row/column pins.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE_DB} state_t;

   localparam logic ROW_IDLE = 1'b1;
   localparam logic COL_IDLE = 1'b1;

   function automatic int code_w(input int n_keys);
      return (n_keys > 2) ? $clog2(n_keys) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to RESET_VAL.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_hist.sv
// Matrix keypad scanner with debounce, single-key rollover and a short key-code history.
// Optional auto-repeat while a key is held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_scan_hist
   import keypad_pkg::*;
#(
   parameter int N_ROWS         = 4,
   parameter int N_COLS         = 4,
   parameter int SCAN_TICKS     = 36000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int N_DIGITS       = 2,
   parameter int REPEAT_DELAY   = 300,
   parameter int REPEAT_TICKS   = 60,
   localparam int CODE_W        = code_w(N_ROWS * N_COLS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_COLS-1:0]          cols_n,
   output logic [N_ROWS-1:0]          rows_n,
   output logic [CODE_W-1:0]          key_code,
   output logic                       key_valid,
   output logic                       key_held,
   output logic [N_DIGITS*CODE_W-1:0] digits
);

   localparam int PS_W  = $clog2(SCAN_TICKS);
   localparam int ROW_W = (N_ROWS > 2) ? $clog2(N_ROWS) : 1;
   localparam int COL_W = (N_COLS > 2) ? $clog2(N_COLS) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS);

   state_t                     state;
   logic [PS_W-1:0]            presc;
   logic                       tick;
   logic [N_COLS-1:0]          cols_s, act, pattern;
   logic [ROW_W-1:0]           row_idx, next_row;
   logic [COL_W-1:0]           low_col, held_col;
   logic [CODE_W-1:0]          new_code, cand_code, push_code;
   logic [DB_W-1:0]            cnt;
   logic [N_DIGITS*CODE_W-1:0] digits_push;
   logic                       rep_fire;

   sync_2ff #(.WIDTH(N_COLS), .RESET_VAL({N_COLS{COL_IDLE}})) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cols_n),
      .q     (cols_s)
   );

   assign act    = ~cols_s;
   assign rows_n = {N_ROWS{ROW_IDLE}} ^ (N_ROWS'(1) << row_idx);
   assign tick   = (presc == PS_W'(SCAN_TICKS - 1));

   always_ff @(posedge clk) begin
      if (reset || tick) presc <= '0;
      else               presc <= presc + 1'b1;
   end

   always_comb begin
      low_col = '0;
      for (int c = N_COLS - 1; c >= 0; c--)
         if (act[c]) low_col = COL_W'(c);
   end

   assign next_row  = (row_idx == ROW_W'(N_ROWS - 1)) ? '0 : row_idx + 1'b1;
   assign new_code  = CODE_W'(row_idx) * CODE_W'(N_COLS) + CODE_W'(low_col);
   // With a one-tick debounce the push happens on the detection tick, before cand_code is loaded.
   assign push_code = (state == SCAN) ? new_code : cand_code;

   generate
      if (N_DIGITS > 1) begin : g_shift
         assign digits_push = {digits[(N_DIGITS-1)*CODE_W-1:0], push_code};
      end else begin : g_single
         assign digits_push = push_code;
      end
   endgenerate

`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_TICKS) ? REPEAT_DELAY : REPEAT_TICKS;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] rep_cnt;
   logic            rep_first;

   assign rep_fire = (rep_cnt + 1'b1) == (rep_first ? RP_W'(REPEAT_DELAY) : RP_W'(REPEAT_TICKS));

   // Survives a RELEASE_DB bounce; only a full return to SCAN restarts the delay.
   always_ff @(posedge clk) begin
      if (reset || state == SCAN) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (tick && state == PRESSED && act[held_col]) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_rep;
   assign unused_rep = ^{REPEAT_DELAY, REPEAT_TICKS};
   assign rep_fire   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         row_idx   <= '0;
         pattern   <= '0;
         held_col  <= '0;
         cand_code <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         digits    <= '0;
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (|act) begin
                     pattern   <= act;
                     held_col  <= low_col;
                     cand_code <= new_code;
                     cnt       <= DB_W'(1);
                     if (DEBOUNCE_TICKS == 1) begin
                        key_code  <= new_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        digits    <= digits_push;
                        state     <= PRESSED;
                     end else begin
                        state <= DEBOUNCE;
                     end
                  end else begin
                     row_idx <= next_row;
                  end
               end
               DEBOUNCE: begin
                  if (act == pattern) begin
                     cnt <= cnt + 1'b1;
                     if (cnt + 1'b1 == DB_LAST) begin
                        key_code  <= cand_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        digits    <= digits_push;
                        cnt       <= '0;
                        state     <= PRESSED;
                     end
                  end else begin
                     cnt   <= '0;
                     state <= SCAN;
                  end
               end
               PRESSED: begin
                  if (!act[held_col]) begin
                     if (DEBOUNCE_TICKS == 1) begin
                        key_held <= 1'b0;
                        cnt      <= '0;
                        state    <= SCAN;
                     end else begin
                        cnt   <= DB_W'(1);
                        state <= RELEASE_DB;
                     end
                  end else if (rep_fire) begin
                     key_valid <= 1'b1;
                     digits    <= digits_push;
                  end
               end
               RELEASE_DB: begin
                  if (act[held_col]) begin
                     cnt   <= '0;
                     state <= PRESSED;
                  end else if (cnt + 1'b1 == DB_LAST) begin
                     key_held <= 1'b0;
                     cnt      <= '0;
                     state    <= SCAN;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_hist.sv
// Directed + randomized bench for keypad_scan_hist (4x4, 4-clk ticks, 3-tick debounce).
// Build with KEYPAD_AUTO_REPEAT_EN to exercise the repeat timing instead of the single-event check.
module tb_keypad_scan_hist;

   localparam int NR = 4;
   localparam int NC = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0] cols_n;
   logic [NR-1:0] rows_n;
   logic [CW-1:0] key_code;
   logic          key_valid, key_held;
   logic [2*CW-1:0] digits;

   int checks = 0;
   int errors = 0;
   int kv_count = 0;
   int cyc = 0;
   int ev_cyc[$];
   logic [CW-1:0] ev_code[$];

   logic [NR-1:0][NC-1:0] keys = '0;
   logic [2*CW-1:0] exp_digits;

   always #5 clk = ~clk;

   keypad_scan_hist #(
      .N_ROWS(NR), .N_COLS(NC), .SCAN_TICKS(4), .DEBOUNCE_TICKS(3), .N_DIGITS(2),
      .REPEAT_DELAY(5), .REPEAT_TICKS(2)
   ) dut (
      .clk(clk), .reset(reset), .cols_n(cols_n), .rows_n(rows_n),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .digits(digits)
   );

   // Passive switch matrix: a closed key pulls its column low while its row is driven low.
   always_comb begin
      cols_n = '1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (keys[r][c] && !rows_n[r]) cols_n[c] = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_valid) begin
         kv_count++;
         ev_cyc.push_back(cyc);
         ev_code.push_back(key_code);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_kv(input int max, output bit ok);
      int k0;
      k0 = kv_count;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         cyc_wait(1);
         if (kv_count != k0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Returns just after row r becomes driven, i.e. at the start of a fresh tick period.
   task automatic align_row(input int r);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !rows_n[r]; i++) cyc_wait(1);
      for (int i = 0; i < 40; i++) begin
         cyc_wait(1);
         if (!rows_n[r]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("align_row", 32'(ok), 1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_rows"}, 32'(rows_n), 32'h0000000e);
      chk({tag, "_valid"}, 32'(key_valid), 0);
      chk({tag, "_held"}, 32'(key_held), 0);
      chk({tag, "_code"}, 32'(key_code), 0);
      chk({tag, "_digits"}, 32'(digits), 0);
   endtask

   task automatic accept_key(input int r, input int c);
      int kv0;
      bit ok;
      logic [CW-1:0] code;
      kv0  = kv_count;
      code = CW'(r * NC + c);
      keys[r][c] = 1'b1;
      wait_kv(200, ok);
      chk("accept_seen", 32'(ok), 1);
      keys[r][c] = 1'b0;
      exp_digits = {exp_digits[CW-1:0], code};
      chk("accept_code", 32'(key_code), 32'(code));
      chk("accept_held", 32'(key_held), 1);
      chk("accept_digits", 32'(digits), 32'(exp_digits));
      cyc_wait(60);
      chk("release_held", 32'(key_held), 0);
      chk("accept_once", kv_count, kv0 + 1);
   endtask

   // Key visible for len ticks (< debounce), then gone: no event, row holds one more tick.
   task automatic bounce(input int r, input int c, input int len);
      int kv0;
      logic [NR-1:0] one, exp_row;
      kv0 = kv_count;
      one = 1;
      align_row(r);
      keys[r][c] = 1'b1;
      cyc_wait(4 * len + 1);
      keys[r][c] = 1'b0;
      cyc_wait(4);
      exp_row = ~(one << r);
      chk("bounce_row_hold", 32'(rows_n), 32'(exp_row));
      cyc_wait(4);
      exp_row = ~(one << ((r + 1) % NR));
      chk("bounce_row_next", 32'(rows_n), 32'(exp_row));
      cyc_wait(40);
      chk("bounce_no_event", kv_count, kv0);
      chk("bounce_held", 32'(key_held), 0);
   endtask

   initial begin
      int kv0;
      bit ok;
      logic [NR-1:0] one, exp_row;

      // 1: reset values and idle row walk
      @(negedge clk);
      reset = 1'b1;
      cyc_wait(2);
      reset = 1'b0;
      exp_digits = '0;
      check_reset_state("reset");
      one = 1;
      for (int k = 1; k <= 5; k++) begin
         cyc_wait(4);
         exp_row = ~(one << (k % NR));
         chk("row_walk", 32'(rows_n), 32'(exp_row));
      end
      chk("idle_no_event", kv_count, 0);

      // 2, 3: directed presses and history
      accept_key(1, 2);
      chk("t2_digits", 32'(digits), 32'h06);
      accept_key(3, 0);
      chk("t3_digits_a", 32'(digits), 32'h6c);
      accept_key(0, 1);
      chk("t3_digits_b", 32'(digits), 32'hc1);

      for (int k = 0; k < 6; k++)
         accept_key(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)));

      // 4: short bounces
      for (int k = 0; k < 3; k++)
         bounce(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)),
                int'($urandom_range(1, 2)));
      chk("bounce_digits", 32'(digits), 32'(exp_digits));

      // 5: rollover - second key ignored until the first is released
      kv0 = kv_count;
      keys[0][0] = 1'b1;
      wait_kv(200, ok);
      chk("roll_first_seen", 32'(ok), 1);
      chk("roll_first_code", 32'(key_code), 0);
      exp_digits = {exp_digits[CW-1:0], 4'd0};
      keys[2][3] = 1'b1;
      cyc_wait(12);
      keys[0][0] = 1'b0;
      chk("roll_single", kv_count, kv0 + 1);
      wait_kv(200, ok);
      chk("roll_second_seen", 32'(ok), 1);
      chk("roll_second_code", 32'(key_code), 11);
      exp_digits = {exp_digits[CW-1:0], 4'd11};
      chk("roll_digits", 32'(digits), 32'(exp_digits));
      keys[2][3] = 1'b0;
      cyc_wait(60);
      chk("roll_count", kv_count, kv0 + 2);

      // 6: reset in the middle of debounce and while pressed
      kv0 = kv_count;
      align_row(1);
      keys[1][1] = 1'b1;
      cyc_wait(6);
      reset = 1'b1;
      cyc_wait(1);
      check_reset_state("rst_db");
      keys = '0;
      cyc_wait(2);
      reset = 1'b0;
      exp_digits = '0;
      chk("rst_db_no_event", kv_count, kv0);
      keys[2][2] = 1'b1;
      wait_kv(200, ok);
      chk("rst_pr_seen", 32'(ok), 1);
      reset = 1'b1;
      cyc_wait(1);
      check_reset_state("rst_pr");
      keys = '0;
      cyc_wait(2);
      reset = 1'b0;
      kv0 = kv_count;
      cyc_wait(40);
      chk("rst_pr_quiet", kv_count, kv0);
      accept_key(2, 1);

`ifdef KEYPAD_AUTO_REPEAT_EN
      // 7: repeat at accept, +5, +7, +9 ticks (4 clk per tick)
      begin
         int n0;
         keys[0][3] = 1'b1;
         wait_kv(200, ok);
         chk("rep_first_seen", 32'(ok), 1);
         n0 = ev_cyc.size() - 1;
         cyc_wait(60);
         keys[0][3] = 1'b0;
         cyc_wait(60);
         chk("rep_enough", 32'(ev_cyc.size() >= n0 + 4), 1);
         if (ev_cyc.size() >= n0 + 4) begin
            chk("rep_gap1", ev_cyc[n0 + 1] - ev_cyc[n0], 20);
            chk("rep_gap2", ev_cyc[n0 + 2] - ev_cyc[n0 + 1], 8);
            chk("rep_gap3", ev_cyc[n0 + 3] - ev_cyc[n0 + 2], 8);
            for (int i = 0; i < 4; i++) chk("rep_code", 32'(ev_code[n0 + i]), 3);
         end
         chk("rep_digits", 32'(digits), 32'h33);
      end
`else
      // long hold still gives exactly one event
      kv0 = kv_count;
      keys[0][3] = 1'b1;
      wait_kv(200, ok);
      chk("hold_seen", 32'(ok), 1);
      cyc_wait(240);
      keys[0][3] = 1'b0;
      cyc_wait(60);
      chk("hold_once", kv_count, kv0 + 1);
      exp_digits = {exp_digits[CW-1:0], 4'd3};
      chk("hold_digits", 32'(digits), 32'(exp_digits));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
